bin2bcd_feeder: RTL and testbench

BIN2BCD_FEEDER -- requirements
Module: bin2bcd_feeder

---
 rtl/bin2bcd_feeder.sv | 111 +++++++++++
 tb/tb_bin2bcd_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_feeder.sv
// bin2bcd_feeder: converts a 16-bit binary value to four BCD digits for a
// 7-segment multiplexer (double-dabble, one bit per cycle), or passes the
// value through unchanged in hex mode. Decimal results above 9999 saturate
// to 9999 and raise ovf.
module bin2bcd_feeder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [15:0] bin,
   input  logic        blank,
   output logic [15:0] number,
   output logic        on,
   output logic        busy,
   output logic        done,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [19:0] acc;
   logic [19:0] acc_adj;
   logic [15:0] sreg;
   logic [15:0] bin_q;
   logic        mode_q;
   logic [4:0]  cnt;
   logic        shown;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic: only IDLE accepts start; SHIFT runs 16 iterations.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = mode ? DONE : SHIFT;
         SHIFT:   if (cnt == 5'd15) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   always_comb begin
      acc_adj = acc;
      for (int unsigned i = 0; i < 5; i++) begin
         if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
   end

   // Datapath and registered outputs; number is written only in DONE so the
   // display never sees partial accumulator values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         sreg   <= '0;
         bin_q  <= '0;
         mode_q <= 1'b0;
         cnt    <= '0;
         number <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         shown  <= 1'b0;
      end else begin
         busy <= (state == SHIFT);
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  bin_q  <= bin;
                  mode_q <= mode;
                  acc    <= '0;
                  sreg   <= bin;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               {acc, sreg} <= {acc_adj, sreg} << 1;
               cnt         <= cnt + 5'd1;
            end
            DONE: begin
               shown <= 1'b1;
               if (mode_q) begin
                  number <= bin_q;
                  ovf    <= 1'b0;
               end else if (acc[19:16] != 4'd0) begin
                  number <= 16'h9999;
                  ovf    <= 1'b1;
               end else begin
                  number <= acc[15:0];
                  ovf    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign on = shown & ~blank;

endmodule

// File: tb/tb_bin2bcd_feeder.sv
// Testbench for bin2bcd_feeder: table vectors, randomized conversions checked
// against an arithmetic reference model, and hand-written timing sequences.
module tb_bin2bcd_feeder;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mode;
   logic [15:0] bin;
   logic        blank;
   logic [15:0] number;
   logic        on;
   logic        busy;
   logic        done;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   bin2bcd_feeder dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mode   (mode),
      .bin    (bin),
      .blank  (blank),
      .number (number),
      .on     (on),
      .busy   (busy),
      .done   (done),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] b;
      logic        m;
      logic [15:0] en;
      logic        eo;
   } vec_t;

   function automatic logic [15:0] ref_number(input logic [15:0] v, input logic m);
      int unsigned n;
      n = v;
      if (m) return v;
      if (n > 9999) return 16'h9999;
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic ref_ovf(input logic [15:0] v, input logic m);
      int unsigned n;
      n = v;
      return !m && (n > 9999);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One conversion from IDLE; optionally re-pulse start (with other data) at
   // sample index pulse_at, which must be ignored.
   task automatic conv(input string tag, input logic [15:0] b, input logic m,
                       input int pulse_at);
      logic [15:0] exp_num;
      logic [15:0] prev_num;
      logic [15:0] num_at_done;
      logic        exp_ovf;
      logic        ovf_at_done;
      logic        on_at_done;
      logic        interim_ok;
      int          busy_cnt;
      int          busy_first;
      int          done_cnt;
      int          done_at;
      exp_num     = ref_number(b, m);
      exp_ovf     = ref_ovf(b, m);
      prev_num    = number;
      num_at_done = '0;
      ovf_at_done = 1'b0;
      on_at_done  = 1'b0;
      interim_ok  = 1'b1;
      busy_cnt    = 0;
      busy_first  = -1;
      done_cnt    = 0;
      done_at     = -1;
      @(negedge clk);
      start = 1'b1;
      bin   = b;
      mode  = m;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      bin   = 16'($urandom);
      mode  = 1'($urandom);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = i;
         end
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_at     = i;
               num_at_done = number;
               ovf_at_done = ovf;
               on_at_done  = on;
            end
         end else if (done_cnt == 0 && number !== prev_num) begin
            interim_ok = 1'b0;
         end
         start = (i == pulse_at);
         if (start) begin
            bin  = 16'd7777;
            mode = 1'($urandom);
         end
      end
      check($sformatf("%s done_count", tag), done_cnt, 1);
      check($sformatf("%s done_at", tag), done_at, m ? 1 : 17);
      check($sformatf("%s number", tag), num_at_done, exp_num);
      check($sformatf("%s ovf", tag), ovf_at_done, exp_ovf);
      check($sformatf("%s on", tag), on_at_done, 1);
      check($sformatf("%s busy_cycles", tag), busy_cnt, m ? 0 : 16);
      if (!m) check($sformatf("%s busy_first", tag), busy_first, 1);
      check($sformatf("%s no_interim", tag), interim_ok, 1);
      check($sformatf("%s number_held", tag), number, exp_num);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [8];
      logic [15:0] rb;
      logic        rm;
      logic [15:0] held;
      int          dn [$];

      vecs[0] = '{16'd1234,  1'b0, 16'h1234, 1'b0};
      vecs[1] = '{16'd0,     1'b0, 16'h0000, 1'b0};
      vecs[2] = '{16'd9999,  1'b0, 16'h9999, 1'b0};
      vecs[3] = '{16'd10000, 1'b0, 16'h9999, 1'b1};
      vecs[4] = '{16'd65535, 1'b0, 16'h9999, 1'b1};
      vecs[5] = '{16'hBEEF,  1'b1, 16'hBEEF, 1'b0};
      vecs[6] = '{16'd42,    1'b0, 16'h0042, 1'b0};
      vecs[7] = '{16'd1,     1'b1, 16'h0001, 1'b0};

      reset = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      bin   = '0;
      blank = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst number", number, 16'h0000);
      check("rst on", on, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst ovf", ovf, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Table vectors against literal expectations.
      foreach (vecs[i]) begin
         conv($sformatf("vec%0d", i), vecs[i].b, vecs[i].m, 0);
         check($sformatf("vec%0d table_number", i), number, vecs[i].en);
         check($sformatf("vec%0d table_ovf", i), ovf, vecs[i].eo);
      end

      // Randomized conversions against the reference model.
      for (int i = 0; i < 12; i++) begin
         rb = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
         rm = ($urandom_range(0, 3) == 0);
         conv($sformatf("rnd%0d", i), rb, rm, 0);
      end

      // Start while busy (SHIFT) and while in DONE must be ignored.
      conv("rej_shift", 16'd42, 1'b0, 5);
      conv("rej_done", 16'd42, 1'b0, 16);

      // Start held high: back-to-back conversions 18 edges apart.
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd123;
      mode  = 1'b0;
      for (int i = 0; i <= 60; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dn.push_back(i);
      end
      start = 1'b0;
      check("held done_count", dn.size() >= 2, 1);
      if (dn.size() >= 2) begin
         check("held first_done", dn[0], 17);
         check("held spacing", dn[1] - dn[0], 18);
      end
      check("held number", number, 16'h0123);
      repeat (25) @(negedge clk);

      // Blanking gates on without touching number.
      held  = number;
      blank = 1'b1;
      #1;
      check("blank on", on, 0);
      check("blank number", number, held);
      blank = 1'b0;
      #1;
      check("unblank on", on, 1);

      // Reset mid-conversion aborts and clears all outputs.
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd5555;
      mode  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b0;
      #1;
      check("midrst number", number, 16'h0000);
      check("midrst on", on, 0);
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst ovf", ovf, 0);
      repeat (2) @(negedge clk);
      check("inrst on", on, 0);
      // First edge after release accepts start.
      reset = 1'b1;
      start = 1'b1;
      bin   = 16'h0321;
      mode  = 1'b1;
      #1;
      check("release on", on, 0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("release done", done, 1);
      check("release number", number, 16'h0321);
      check("release on_after", on, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
